bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one shift per clock. Successor to the 4-bit combinational decimal/BCD mapping: arbitrary input width, configurable digit count, and overflow detection. Sits between binary counters/datapaths and display/UART formatting logic. Valid/ready handshake on both sides.

Parameters:
BIN_W, 8, width of binary input (1..32)
DIGITS, 3, number of BCD output digits (1..10); output width 4*DIGITS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
bin_in  input  BIN_W  unsigned binary value to convert
in_valid  input  1  bin_in valid
in_ready  output  1  converter can accept a value
bcd_out  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0]
ovf  output  1  result needed more than DIGITS digits; qualified by out_valid
out_valid  output  1  bcd_out/ovf valid
out_ready  input  1  downstream accepts result
busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- One clock, synchronous active-low reset. rst_n=0 at a rising edge: state=IDLE, bcd_out=0, ovf=0, out_valid=0, busy=0, shift counter=0, internal binary shift register=0; in_ready=1 from the following cycle.
- Reset mid-conversion or while holding a result: the operation is abandoned, nothing is emitted, and the same reset values apply.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. in_valid=1 at an edge: capture bin_in, clear BCD register and ovf, counter=0, go to SHIFT. in_valid=0: stay in IDLE.
- SHIFT: in_ready=0, busy=1. Each edge:
  - every digit >=5 gets +3 (4-bit, no carry between digits);
  - {BCD reg, bin reg} shifts left by 1;
  - the bit leaving the top digit ORs into ovf (sticky);
  - counter increments.
  After the BIN_W-th shift, go to DONE.
- DONE: out_valid=1 and bcd_out/ovf stable. Hold until out_ready=1 at an edge, then go to IDLE with out_valid=0.
- Latency: input accepted at edge k; out_valid high after edge k+BIN_W. Minimum initiation interval is BIN_W+2 cycles: one IDLE cycle between results, and no accept in DONE.
- in_valid while in_ready=0 is ignored; bin_in changes during SHIFT do not affect the result.
- out_ready while out_valid=0 is ignored. out_valid does not drop without a handshake.
- Overflow: if 10^DIGITS <= value, ovf=1 and bcd_out = value mod 10^DIGITS.
- Corner values: bin_in=0 gives all-zero digits and ovf=0. Max input 2^BIN_W-1 must convert correctly whenever DIGITS is sufficient.
- BIN_W=1: exactly 1 shift cycle.

Optional Feature:
BCD_SAT_EN
- Defined: when ovf=1, bcd_out presents all digits = 4'd9 (saturated), and ovf is still asserted.
- Undefined: when ovf=1, bcd_out presents value mod 10^DIGITS.
- No effect when ovf=0.

Test Plan:
1. BIN_W=8, DIGITS=3: reset, then bin_in=255 with in_valid pulse -> out_valid after exactly 8 cycles, bcd_out=12'h255, ovf=0, busy high those 8 cycles.
2. Inputs 0, 9, 10, 99, 100 sent back-to-back with in_valid held high, out_ready=1 -> 12'h000, 12'h009, 12'h010, 12'h099, 12'h100; in_ready low during SHIFT/DONE; one accept per 10 cycles.
3. Backpressure: bin_in=128 with out_ready=0 for 20 cycles -> out_valid held, bcd_out=12'h128 stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
4. DIGITS=2, bin_in=150 -> ovf=1, bcd_out=8'h50. With BCD_SAT_EN defined -> bcd_out=8'h99, ovf=1.
5. rst_n=0 at shift 4 of bin_in=200 -> no out_valid, all outputs 0, in_ready=1 after release. Then bin_in=37 -> 12'h037.
6. BIN_W=16, DIGITS=5, bin_in=65535 -> 20'h65535 after 16 cycles, ovf=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock; define BCD_SAT_EN to saturate bcd_out to all nines on overflow
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  // next state: capture in IDLE, add-3/shift in SHIFT, wait for handshake in DONE
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        bin_d   = bin_in;
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        ovf_d          = ovf_q | adj[BW-1];
        cnt_d          = cnt_q + CW'(1);
        state_d        = cnt_q == CW'(BIN_W - 1) ? DONE : SHIFT;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == SHIFT;
  assign out_valid = state_q == DONE;
  assign ovf       = ovf_q;
`ifdef BCD_SAT_EN
  assign bcd_out = ovf_q ? {DIGITS{4'h9}} : bcd_q;
`else
  assign bcd_out = bcd_q;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq across four parameter sets
module tb_bin_to_bcd_seq;
`ifdef BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] bin16 = '0;
  logic [11:0] a_bcd; logic a_ovf, a_ov, a_ir, a_busy;
  logic [7:0]  b_bcd; logic b_ovf, b_ov, b_ir, b_busy;
  logic [19:0] c_bcd; logic c_ovf, c_ov, c_ir, c_busy;
  logic [3:0]  d_bcd; logic d_ovf, d_ov, d_ir, d_busy;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bin_in(bin16[7:0]), .in_valid(in_valid),
    .in_ready(a_ir), .bcd_out(a_bcd), .ovf(a_ovf), .out_valid(a_ov), .out_ready(out_ready), .busy(a_busy));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .bin_in(bin16[7:0]), .in_valid(in_valid),
    .in_ready(b_ir), .bcd_out(b_bcd), .ovf(b_ovf), .out_valid(b_ov), .out_ready(out_ready), .busy(b_busy));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (.clk(clk), .rst_n(rst_n), .bin_in(bin16), .in_valid(in_valid),
    .in_ready(c_ir), .bcd_out(c_bcd), .ovf(c_ovf), .out_valid(c_ov), .out_ready(out_ready), .busy(c_busy));
  bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) u_d (.clk(clk), .rst_n(rst_n), .bin_in(bin16[0]), .in_valid(in_valid),
    .in_ready(d_ir), .bcd_out(d_bcd), .ovf(d_ovf), .out_valid(d_ov), .out_ready(out_ready), .busy(d_busy));

  // reference: plain decimal arithmetic on the value
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
    longint unsigned p = 1, m;
    logic [63:0] r = '0;
    for (int i = 0; i < d; i++) p *= 10;
    m = v % p;
    for (int i = 0; i < d; i++) begin r[4*i+:4] = 4'(m % 10); m /= 10; end
    if (SAT && v >= p) for (int i = 0; i < d; i++) r[4*i+:4] = 4'd9;
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int d);
    longint unsigned p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    return v >= p;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // one transaction with out_ready held low long enough to see backpressure
  task automatic run(input logic [15:0] v, input logic [11:0] ea, input logic eao, input logic [7:0] eb, input logic ebo);
    int la = 0, lb = 0, lc = 0, ld = 0, bz = 0, unst = 0;
    bin16 = v; in_valid = 1'b1;
    step();
    in_valid = 1'b0; bin16 = ~v;
    for (int i = 0; i < 28; i++) begin
      if (a_busy) bz++;
      if (a_ov && (a_bcd !== ea || a_ovf !== eao || a_ir)) unst++;
      step();
      if (a_ov && la == 0) la = i + 1;
      if (b_ov && lb == 0) lb = i + 1;
      if (c_ov && lc == 0) lc = i + 1;
      if (d_ov && ld == 0) ld = i + 1;
    end
    chk("lat_a", 64'(la), 64'd8);
    chk("lat_b", 64'(lb), 64'd8);
    chk("lat_c", 64'(lc), 64'd16);
    chk("lat_d", 64'(ld), 64'd1);
    chk("busy_cycles_a", 64'(bz), 64'd8);
    chk("hold_a", 64'(unst), 64'd0);
    chk("bcd_a", 64'(a_bcd), 64'(ea));
    chk("ovf_a", 64'(a_ovf), 64'(eao));
    chk("bcd_b", 64'(b_bcd), 64'(eb));
    chk("ovf_b", 64'(b_ovf), 64'(ebo));
    chk("bcd_c", 64'(c_bcd), ref_bcd(64'(v), 5));
    chk("ovf_c", 64'(c_ovf), 64'(ref_ovf(64'(v), 5)));
    chk("bcd_d", 64'(d_bcd), ref_bcd(64'(v[0]), 1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release", {a_ov, b_ov, c_ov, d_ov, a_ir, b_ir, c_ir, d_ir}, 64'h0F);
  endtask

  typedef struct { logic [15:0] v; logic [11:0] ea; logic eao; logic [7:0] eb; logic ebo; } vec_t;
  vec_t tbl[10];
  logic [15:0] vals[5];
  logic [11:0] bexp[5];

  initial begin
    int idx, got, last, viol, seen;
    logic [15:0] v;
    tbl[0] = '{16'd0,     12'h000, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{16'd9,     12'h009, 1'b0, 8'h09, 1'b0};
    tbl[2] = '{16'd10,    12'h010, 1'b0, 8'h10, 1'b0};
    tbl[3] = '{16'd99,    12'h099, 1'b0, 8'h99, 1'b0};
    tbl[4] = '{16'd100,   12'h100, 1'b0, SAT ? 8'h99 : 8'h00, 1'b1};
    tbl[5] = '{16'd150,   12'h150, 1'b0, SAT ? 8'h99 : 8'h50, 1'b1};
    tbl[6] = '{16'd255,   12'h255, 1'b0, SAT ? 8'h99 : 8'h55, 1'b1};
    tbl[7] = '{16'd128,   12'h128, 1'b0, SAT ? 8'h99 : 8'h28, 1'b1};
    tbl[8] = '{16'd37,    12'h037, 1'b0, 8'h37, 1'b0};
    tbl[9] = '{16'hFFFF,  12'h255, 1'b0, SAT ? 8'h99 : 8'h55, 1'b1};
    vals = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100};
    bexp = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
    step();
    do_reset();
    chk("reset_state", {a_ov, a_busy, a_ovf, a_ir, b_ov, c_ov, d_ov}, 64'b0001000);
    chk("reset_bcd", {a_bcd, c_bcd}, 64'd0);
    for (int t = 0; t < 10; t++) run(tbl[t].v, tbl[t].ea, tbl[t].eao, tbl[t].eb, tbl[t].ebo);
    for (int t = 0; t < 40; t++) begin
      v = (t == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      run(v, 12'(ref_bcd(64'(v[7:0]), 3)), ref_ovf(64'(v[7:0]), 3),
          8'(ref_bcd(64'(v[7:0]), 2)), ref_ovf(64'(v[7:0]), 2));
    end
    do_reset();
    idx = 0; got = 0; last = 0; viol = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (a_ir) begin
        if (idx < 5) begin
          bin16 = vals[idx];
          if (idx > 0) chk("accept_interval", 64'(cyc - last), 64'd10);
          last = cyc; idx++;
        end else in_valid = 1'b0;
      end
      if (a_ov) begin
        if (got < 5) chk("b2b_bcd", 64'(a_bcd), 64'(bexp[got]));
        got++;
      end
      if ((a_busy || a_ov) && a_ir) viol++;
      step();
    end
    chk("b2b_count", 64'(got), 64'd5);
    chk("b2b_ready_low", 64'(viol), 64'd0);
    do_reset();
    bin16 = 16'd200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset_state", {a_ov, a_busy, a_ovf, a_ir}, 64'b0001);
    chk("midreset_bcd", 64'(a_bcd), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_ov) seen++;
      step();
    end
    chk("midreset_no_output", 64'(seen), 64'd0);
    run(16'd37, 12'h037, 1'b0, 8'h37, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
